// File: rtl/test_seq_pkg.sv
// Shared types and constants for the self-test frame sequencer.
package test_seq_pkg;

   typedef enum logic [1:0] {
      HUNT,
      LOAD,
      RUN,
      TX
   } seq_state_t;

   localparam logic [7:0]  STATUS_TAG        = 8'hC5;
   localparam logic [3:0]  CODE_OK           = 4'd0;
   localparam logic [3:0]  CODE_TIMEOUT      = 4'd1;
   localparam logic [31:0] DEFAULT_SYNC_WORD = 32'hA5A5_5A5A;

   function automatic logic [7:0] byte_xor(input logic [31:0] w);
      return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
   endfunction

endpackage

// File: rtl/seq_timeout_cnt.sv
// Clear/enable cycle counter whose expire flag marks the last allowed RUN cycle.
module seq_timeout_cnt #(
   parameter int TIMEOUT = 1024,
   localparam int W = $clog2(TIMEOUT)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count,
   output logic         expire
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_reg <= '0;
      else if (clr)
         count_reg <= '0;
      else if (en)
         count_reg <= count_reg + 1'b1;
   end

   assign count  = count_reg;
   assign expire = (count_reg == W'(TIMEOUT - 1));

endmodule

// File: rtl/test_sequencer.sv
// Frame controller for the self-test datapath: sync hunt, payload load, run with timeout, result TX.
// Optional TEST_SEQ_CHK_EN adds a byte-XOR checksum of the loaded payload to the status word.
module test_sequencer
   import test_seq_pkg::*;
#(
   parameter int          N_WORDS   = 8,
   parameter logic [31:0] SYNC_WORD = DEFAULT_SYNC_WORD,
   parameter int          TIMEOUT   = 1024
) (
   input  logic        div_8_clk,
   input  logic        rst,
   input  logic        f_layer,
   input  logic [31:0] word_in,
   input  logic        word_valid,
   input  logic        sort_finish,
   output logic        load_en,
   output logic        st_start,
   output logic        tx_out,
   output logic [31:0] tx_word,
   input  logic [31:0] st_word,
   output logic        busy,
   output logic        err
);

   localparam int         TW     = $clog2(TIMEOUT);
   localparam logic [7:0] N_LAST = 8'(N_WORDS);

   seq_state_t state_reg, state_next;
   logic [7:0] wcnt_reg, wcnt_next;
   logic [7:0] tx_cnt_reg, tx_cnt_next;
   logic [7:0] drop_cnt_reg, drop_cnt_next;
   logic [3:0] code_reg, code_next;
   logic       err_reg, err_next;
   logic       load_c;
   logic       tcnt_clr, tcnt_en, tcnt_expire;
   logic [TW-1:0] tcnt;
   logic [7:0] chk;
   logic [31:0] status_word;

   seq_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_tcnt (
      .clk    (div_8_clk),
      .rst    (rst),
      .clr    (tcnt_clr),
      .en     (tcnt_en),
      .count  (tcnt),
      .expire (tcnt_expire)
   );

   always_ff @(posedge div_8_clk or posedge rst) begin
      if (rst) begin
         state_reg    <= HUNT;
         wcnt_reg     <= '0;
         tx_cnt_reg   <= '0;
         drop_cnt_reg <= '0;
         code_reg     <= CODE_OK;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wcnt_reg     <= wcnt_next;
         tx_cnt_reg   <= tx_cnt_next;
         drop_cnt_reg <= drop_cnt_next;
         code_reg     <= code_next;
         err_reg      <= err_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      wcnt_next     = wcnt_reg;
      tx_cnt_next   = tx_cnt_reg;
      drop_cnt_next = drop_cnt_reg;
      code_next     = code_reg;
      err_next      = err_reg;
      load_c        = 1'b0;
      tcnt_clr      = 1'b0;
      tcnt_en       = 1'b0;

      case (state_reg)
         HUNT: begin
            if (word_valid && f_layer) begin
               // first-layer frames have no sync word: this word is already payload
               load_c    = 1'b1;
               wcnt_next = 8'd1;
               if (N_LAST == 8'd1) begin
                  state_next = RUN;
                  tcnt_clr   = 1'b1;
                  code_next  = CODE_OK;
               end else begin
                  state_next = LOAD;
               end
            end else if (word_valid && word_in == SYNC_WORD) begin
               state_next = LOAD;
               wcnt_next  = '0;
            end
         end
         LOAD: begin
            if (word_valid) begin
               load_c    = 1'b1;
               wcnt_next = wcnt_reg + 8'd1;
               if (wcnt_reg + 8'd1 == N_LAST) begin
                  state_next = RUN;
                  tcnt_clr   = 1'b1;
                  code_next  = CODE_OK;
               end
            end
         end
         RUN: begin
            tcnt_en = 1'b1;
            if (sort_finish) begin
               state_next  = TX;
               tx_cnt_next = '0;
            end else if (tcnt_expire) begin
               state_next  = TX;
               tx_cnt_next = '0;
               code_next   = CODE_TIMEOUT;
               err_next    = 1'b1;
            end
         end
         TX: begin
            if (tx_cnt_reg == N_LAST)
               state_next = HUNT;
            else
               tx_cnt_next = tx_cnt_reg + 8'd1;
         end
         default: state_next = HUNT;
      endcase

      if ((state_reg == RUN || state_reg == TX) && word_valid && drop_cnt_reg != 8'hFF)
         drop_cnt_next = drop_cnt_reg + 8'd1;
   end

`ifdef TEST_SEQ_CHK_EN
   logic [7:0] chk_reg;

   // the first payload word of a frame restarts the accumulator
   always_ff @(posedge div_8_clk or posedge rst) begin
      if (rst)
         chk_reg <= '0;
      else if (load_c)
         chk_reg <= ((state_reg == HUNT) ? 8'h00 : chk_reg) ^ byte_xor(word_in);
      else if (state_reg == HUNT && state_next == LOAD)
         chk_reg <= '0;
   end

   assign chk = chk_reg;
`else
   assign chk = 8'h00;
`endif

   assign status_word = {STATUS_TAG, 4'b0000, code_reg, wcnt_reg, chk};

   assign load_en  = load_c & ~rst;
   assign st_start = (state_reg == RUN) && (tcnt == '0);
   assign tx_out   = (state_reg == TX);
   assign tx_word  = (state_reg != TX)      ? 32'h0 :
                     (tx_cnt_reg == N_LAST) ? status_word : st_word;
   assign busy     = (state_reg != HUNT);
   assign err      = err_reg;

endmodule

// File: tb/tb_test_sequencer.sv
// Randomized frame-level bench for test_sequencer against a transaction model of one frame.
module tb_test_sequencer;

   localparam int          N    = 8;
   localparam int          TO   = 1024;
   localparam logic [31:0] SYNC = 32'hA5A5_5A5A;

   logic        div_8_clk = 1'b0;
   logic        rst;
   logic        f_layer;
   logic [31:0] word_in;
   logic        word_valid;
   logic        sort_finish;
   logic        load_en;
   logic        st_start;
   logic        tx_out;
   logic [31:0] tx_word;
   logic [31:0] st_word;
   logic        busy;
   logic        err;

   test_sequencer dut (
      .div_8_clk   (div_8_clk),
      .rst         (rst),
      .f_layer     (f_layer),
      .word_in     (word_in),
      .word_valid  (word_valid),
      .sort_finish (sort_finish),
      .load_en     (load_en),
      .st_start    (st_start),
      .tx_out      (tx_out),
      .tx_word     (tx_word),
      .st_word     (st_word),
      .busy        (busy),
      .err         (err)
   );

   always #5 div_8_clk = ~div_8_clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_load, n_start, n_tx;
   logic [31:0] got_q[$];
   logic        err_exp = 1'b0;
   logic        s_load_en, s_st_start, s_tx_out, s_busy, s_err;
   logic [31:0] s_tx_word;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // one cycle: outputs sampled at the falling edge, next inputs driven just after the rising edge
   task automatic tick();
      @(negedge div_8_clk);
      s_load_en  = load_en;
      s_st_start = st_start;
      s_tx_out   = tx_out;
      s_tx_word  = tx_word;
      s_busy     = busy;
      s_err      = err;
      if (load_en) begin
         n_load++;
         got_q.push_back(word_in);
      end
      if (st_start) n_start++;
      if (tx_out)   n_tx++;
      @(posedge div_8_clk);
      #1;
   endtask

   task automatic load_words(input logic [31:0] pay[N], input int count);
      for (int i = 0; i < count; i++) begin
         int gaps = int'($urandom_range(0, 2));
         for (int g = 0; g < gaps; g++) begin
            word_valid = 1'b0;
            word_in    = $urandom;
            tick();
         end
         word_valid = 1'b1;
         word_in    = pay[i];
         tick();
         check_val("payload_load_en", 32'(s_load_en), 32'd1);
      end
   endtask

   task automatic run_frame(input bit fl, input int n_garb, input int d, input bit seq_payload);
      logic [31:0] pay[N];
      logic [7:0]  chk_e;
      logic        timed;
      int          run_len;
      chk_e = 8'h00;
      for (int i = 0; i < N; i++) begin
         pay[i] = seq_payload ? 32'(i + 1) : (($urandom_range(0, 7) == 0) ? SYNC : $urandom);
`ifdef TEST_SEQ_CHK_EN
         chk_e = chk_e ^ pay[i][31:24] ^ pay[i][23:16] ^ pay[i][15:8] ^ pay[i][7:0];
`endif
      end
      n_load = 0; n_start = 0; n_tx = 0;
      got_q.delete();
      f_layer     = fl;
      sort_finish = 1'b0;

      if (!fl) begin
         for (int g = 0; g < n_garb; g++) begin
            word_valid = ($urandom_range(0, 1) == 1);
            word_in    = (g == 0) ? 32'h1234_5678 : $urandom;
            if (word_in == SYNC) word_in = word_in ^ 32'h1;
            tick();
            check_val("hunt_load_en", 32'(s_load_en), 32'd0);
         end
         word_valid = 1'b1;
         word_in    = SYNC;
         tick();
         check_val("sync_not_loaded", 32'(s_load_en), 32'd0);
         check_val("hunt_busy", 32'(s_busy), 32'd0);
      end

      load_words(pay, N);

      timed   = (d > TO - 1);
      run_len = timed ? TO : d + 1;
      for (int k = 0; k < run_len; k++) begin
         word_valid  = ($urandom_range(0, 1) == 1);
         word_in     = $urandom;
         sort_finish = (k >= d);
         tick();
         if (k == 0) begin
            check_val("start_pulse", 32'(s_st_start), 32'd1);
            check_val("run_busy", 32'(s_busy), 32'd1);
         end
         if (k == run_len - 1)
            check_val("run_no_tx", 32'(s_tx_out), 32'd0);
      end
      err_exp = err_exp | timed;

      for (int t = 0; t <= N; t++) begin
         logic [31:0] exp_w;
         word_valid  = ($urandom_range(0, 1) == 1);
         word_in     = $urandom;
         sort_finish = ($urandom_range(0, 1) == 1);
         st_word     = $urandom;
         tick();
         exp_w = (t < N) ? st_word : {8'hC5, 4'h0, (timed ? 4'h1 : 4'h0), 8'(N), chk_e};
         check_val("tx_out", 32'(s_tx_out), 32'd1);
         check_val((t < N) ? "tx_result" : "tx_status", s_tx_word, exp_w);
         if (t == 0) check_val("err_flag", 32'(s_err), 32'(err_exp));
      end

      word_valid  = 1'b0;
      sort_finish = 1'b0;
      tick();
      check_val("tx_end", 32'(s_tx_out), 32'd0);
      check_val("idle_busy", 32'(s_busy), 32'd0);
      check_val("load_count", 32'(n_load), 32'(N));
      check_val("start_count", 32'(n_start), 32'd1);
      check_val("tx_count", 32'(n_tx), 32'(N + 1));
      for (int i = 0; i < N; i++)
         check_val("loaded_word", (i < got_q.size()) ? got_q[i] : 32'hxxxx_xxxx, pay[i]);
      $display("frame f_layer=%0d finish_at=%0d timeout=%0d chk=%h errors=%0d", fl, d, timed, chk_e, n_errors);
   endtask

   initial begin
      logic [31:0] pay3[N];
      rst = 1'b1; f_layer = 1'b0; word_in = '0; word_valid = 1'b0;
      sort_finish = 1'b0; st_word = '0;
      @(posedge div_8_clk); @(posedge div_8_clk); #1;
      check_val("rst_load_en", 32'(load_en), 32'd0);
      check_val("rst_st_start", 32'(st_start), 32'd0);
      check_val("rst_tx_out", 32'(tx_out), 32'd0);
      check_val("rst_tx_word", tx_word, 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_err", 32'(err), 32'd0);
      rst = 1'b0;
      tick();

      run_frame(1'b0, 3, 20, 1'b0);
      run_frame(1'b1, 0, 20, 1'b1);
      run_frame(1'b0, 2, 5000, 1'b0);
      run_frame(1'b0, 1, TO - 1, 1'b0);

      // abort a frame part-way through loading
      f_layer = 1'b0;
      word_valid = 1'b1; word_in = SYNC;
      tick();
      for (int i = 0; i < N; i++) pay3[i] = $urandom;
      load_words(pay3, 3);
      word_valid = 1'b1; word_in = $urandom;
      rst = 1'b1;
      #2;
      check_val("abort_load_en", 32'(load_en), 32'd0);
      check_val("abort_busy", 32'(busy), 32'd0);
      check_val("abort_tx_out", 32'(tx_out), 32'd0);
      check_val("abort_err", 32'(err), 32'd0);
      @(posedge div_8_clk); #1;
      rst = 1'b0; word_valid = 1'b0;
      err_exp = 1'b0;
      tick();
      run_frame(1'b0, 2, 10, 1'b0);

      for (int f = 0; f < 8; f++)
         run_frame($urandom_range(0, 1) == 1, int'($urandom_range(0, 4)), int'($urandom_range(0, 40)), 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
